// File: rtl/popcount_pkg.sv
// Shared sizing helpers for the bit-counting blocks.
package popcount_pkg;

    function automatic int cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/popcount_core.sv
// Registered population count with load enable; holds its value when en is low.
module popcount_core
    import popcount_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [DATA_WIDTH-1:0]               data,
    output logic [cnt_width(DATA_WIDTH)-1:0]    count
);
    localparam int CNT_W = cnt_width(DATA_WIDTH);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                count_d = count_d + CNT_W'(data[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin arbiter feeding one shared two-stage popcount pipeline.
module popcount_arbiter
    import popcount_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                res_valid,
    output logic [id_width(NUM_REQ)-1:0]        res_id,
    output logic [cnt_width(DATA_WIDTH)-1:0]    res_count,
    input  logic                                res_ready
);
    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(DATA_WIDTH);

    logic [ID_W-1:0]       rr_ptr_d,    rr_ptr_q;
    logic                  s1_valid_d,  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_d,   s1_data_q;
    logic [ID_W-1:0]       s1_id_d,     s1_id_q;
    logic                  res_valid_d, res_valid_q;
    logic [ID_W-1:0]       res_id_d,    res_id_q;
    logic [CNT_W-1:0]      core_count;

    logic gnt_found;
    int   gnt_idx;
    int   scan_idx;
    logic s1_can_load;
    logic s2_can_load;
    logic s2_load;
    logic accept;

    assign s2_can_load = !res_valid_q || res_ready;
    assign s1_can_load = !s1_valid_q || s2_can_load;
    assign s2_load     = s1_valid_q && s2_can_load;

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign accept = gnt_found && s1_can_load && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;

        if (s2_can_load) begin
            s1_valid_d  = 1'b0;
            res_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            res_id_d = s1_id_q;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            s1_id_d    = ID_W'(gnt_idx);
            rr_ptr_d   = ID_W'((gnt_idx + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
        end
    end

    popcount_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .en    (s2_load),
        .data  (s1_data_q),
        .count (core_count)
    );

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_count = core_count;

endmodule

// File: doc/popcount_arbiter.md
# popcount_arbiter

Shares one registered population-count datapath between NUM_REQ independent requesters. Each cycle it selects one valid requester round-robin, counts the set bits of that requester's word, and returns the count tagged with the requester index on a single result port with backpressure. It sits between the bit-vector producers and the downstream consumers of bit counts, and replaces per-requester counter instances.

## Interface
- DATA_WIDTH, 32, width of each request word (≥2).
- NUM_REQ, 4, number of requesters (≥2).
- Derived: ID_W = $clog2(NUM_REQ); CNT_W = $clog2(DATA_WIDTH)+1. These are not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i presents a word.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  bit i: requester i word is accepted this cycle. At most one bit is high.
- res_valid  out  1  result available.
- res_id  out  ID_W  index of the requester that owns the result.
- res_count  out  CNT_W  number of 1 bits in that word, range 0..DATA_WIDTH.
- res_ready  in  1  consumer accepts the result.

## Operation
- Two-stage pipeline:
  - S1 holds the selected word and id (s1_valid).
  - S2 holds the count and id (drives the res_* outputs).
- Grant (combinational):
  - Start at rr_ptr and take the first index i, scanning upward with wrap, whose req_valid[i] is high.
  - req_ready[i] = grant[i] && s1_can_load.
- s1_can_load = !s1_valid || s2_can_load.
- s2_can_load = !res_valid || res_ready.
- Accept (req_valid[i] && req_ready[i]):
  - S1 captures req_data slice i and id i.
  - s1_valid goes to 1.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- rr_ptr is unchanged on cycles with no accept.
- S1 → S2 when s1_valid && s2_can_load:
  - res_count = popcount(S1 word), computed zero-extended in CNT_W. No overflow is possible; all-ones gives exactly DATA_WIDTH.
  - res_id = S1 id; res_valid goes to 1.
- If s1_valid = 0 and s2_can_load = 1, res_valid goes to 0 at the clock edge.
- Stall (res_valid && !res_ready):
  - res_id and res_count are held stable.
  - S1 is held if valid; if S1 is empty, one more word may be loaded into it.
- Simultaneous drain and load in the same cycle is allowed at both stages. Full throughput is one result per cycle.
- A requester must hold req_valid and req_data stable until its ready is seen. The block does not depend on this for correctness, because it samples only on accept.
- Reset mid-operation:
  - All in-flight words are discarded; no result is produced for them.
  - rr_ptr = 0, s1_valid = 0.
  - res_valid = 0, res_id = 0, res_count = 0.
- While rst is asserted, req_ready is forced to 0.

## Timing
- Reset values: req_ready 0, res_valid 0, res_id 0, res_count 0; internal rr_ptr 0, s1_valid 0.
- Latency: a word accepted at edge t gives res_valid = 1 after edge t+1 (2 cycles from acceptance to result), provided there is no stall.
- Ordering: results leave in acceptance order; no reordering.
- Fairness: with all requesters continuously valid and res_ready = 1, grants rotate 0,1,…,NUM_REQ-1,0,…
- Worst-case wait: a continuously valid requester is granted within NUM_REQ accepts.
- Backpressure: with res_ready = 0, at most 2 words are in flight (S1 + S2). req_ready is 0 from then until res_ready returns.
- No combinational path from req_data to any output. req_ready depends combinationally on req_valid, res_valid and res_ready.

## Structure
- Shared package popcount_pkg:
  - function cnt_width(dw) returning $clog2(dw)+1.
  - function id_width(n) returning max(1, $clog2(n)).
  - Used for ID_W and CNT_W here and in any other counting block.
- Sub-module popcount_core:
  - Parameter DATA_WIDTH; inputs clk, rst, en, data; output count.
  - Registered popcount with load enable, reset to 0. Implements S2's count register.
  - Arbiter logic and pipeline control stay in popcount_arbiter.
- Expected size: about 150–250 lines total.

## Test plan
- Reset during traffic: assert rst while S1 and S2 are full → res_valid = 0 immediately and after release; the first grant after release goes to requester 0.
- Single requester: NUM_REQ = 4, DATA_WIDTH = 32, only req 2 valid with data 0xF0F0_000F, res_ready = 1 → res_valid 2 cycles after accept, res_id = 2, res_count = 12.
- Boundaries: data 0x0000_0000 → count 0; data 0xFFFF_FFFF → count 32 (6-bit 100000); data 0x8000_0001 → count 2.
- Round-robin: all four requesters valid continuously with distinct words → res_id sequence 0,1,2,3,0,1,…, one result per cycle, and each count matches its word.
- Backpressure: res_ready held at 0 for 5 cycles with all requesters valid → exactly 2 accepts, then req_ready = 0 and res_count/res_id stable. When res_ready is released, results drain in order with no loss or duplication.
- Pointer wrap: rr_ptr = 3 and only req 1 valid → grant goes to 1 and rr_ptr becomes 2. Next, req 1 and req 2 both valid → grant goes to 2.
